// File: rtl/reram_array_ctrl.sv
// ReRAM array controller: command-word writes into a ROWS x COLS array with a bounded
// address queue, queue-mode or direct-address reads with abort, and registered status outputs.
module reram_array_ctrl #(
  parameter int unsigned ROWS    = 32,
  parameter int unsigned COLS    = 32,
  parameter int unsigned DW      = 16,
  parameter int unsigned QDEPTH  = 32,
  parameter int unsigned RD_DLY  = 44,
  parameter int unsigned WR_DLY  = 0,
  parameter int unsigned RD_HOLD = 1
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic                        EN,
  input  logic                        R_WB,
  input  logic [31:0]                 wbs_dat_i,
  output logic [31:0]                 read_data,
  output logic                        func_ack,
  output logic                        func_err,
  output logic                        busy,
  output logic [$clog2(QDEPTH+1)-1:0] q_count,
  output logic                        q_full,
  output logic                        q_empty
);

  localparam int unsigned CW     = $clog2(QDEPTH + 1);
  localparam int unsigned PW     = $clog2(QDEPTH);
  localparam int unsigned Cells  = ROWS * COLS;
  localparam int unsigned AW     = $clog2(Cells);
  localparam int unsigned MaxRw  = (RD_DLY > WR_DLY) ? RD_DLY : WR_DLY;
  localparam int unsigned MaxDly = (MaxRw > RD_HOLD) ? MaxRw : RD_HOLD;
  localparam int unsigned TW     = $clog2(MaxDly + 1);

  typedef enum logic [1:0] {StIdle, StWrite, StRdWait, StRdHold} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [4:0]    row_q, row_d, col_q, col_d;
  logic          dir_q, dir_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          ack_q, ack_d, err_q, err_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          busy_q, full_q, empty_q;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wptr_q, rptr_q;
  logic [DW-1:0] mem_q [Cells];
  logic [9:0]    addrq_q [QDEPTH];

  // Flattened cell index for a {row, col} pair already known to be in range.
  function automatic logic [AW-1:0] cell_idx(input logic [4:0] row, input logic [4:0] col);
    return AW'(32'(row) * COLS + 32'(col));
  endfunction

  // Command word decode.
  logic [4:0]    cmd_row, cmd_col;
  logic          cmd_dir, cmd_in_range;
  logic [DW-1:0] cmd_data;
  logic          unused_cmd_bits;
  assign cmd_dir         = wbs_dat_i[31];
  assign cmd_row         = wbs_dat_i[29:25];
  assign cmd_col         = wbs_dat_i[24:20];
  assign cmd_data        = wbs_dat_i[DW-1:0];
  assign unused_cmd_bits = ^{wbs_dat_i[30], wbs_dat_i[19:DW]};
  assign cmd_in_range    = (32'(cmd_row) < ROWS) && (32'(cmd_col) < COLS);

  logic wr_req, wr_bad, wr_go, rd_req, rd_bad, rd_go;
  logic wr_done, rd_abort, rd_done, hold_done;
  assign wr_req    = (state_q == StIdle) && EN && !R_WB;
  assign wr_bad    = wr_req && (full_q || !cmd_in_range);
  assign wr_go     = wr_req && !wr_bad;
  assign rd_req    = (state_q == StIdle) && EN && R_WB;
  assign rd_bad    = rd_req && (cmd_dir ? !cmd_in_range : empty_q);
  assign rd_go     = rd_req && !rd_bad;
  assign wr_done   = (state_q == StWrite) && (cnt_q == TW'(1));
  assign rd_abort  = (state_q == StRdWait) && !EN;
  assign rd_done   = (state_q == StRdWait) && EN && (cnt_q == TW'(1));
  assign hold_done = (state_q == StRdHold) && (cnt_q == TW'(1));

  // Read source: latched address in direct mode, oldest queued address otherwise.
  logic [4:0]    rd_row, rd_col;
  logic [DW-1:0] rd_word;
  assign {rd_row, rd_col} = dir_q ? {row_q, col_q} : addrq_q[rptr_q];
  assign rd_word          = mem_q[cell_idx(rd_row, rd_col)];

  // Commit source: live command when writes are immediate, latched command otherwise.
  logic          push, pop;
  logic [4:0]    c_row, c_col;
  logic [DW-1:0] c_data;
  always_comb begin
    if (WR_DLY == 0) begin
      push   = wr_go;
      c_row  = cmd_row;
      c_col  = cmd_col;
      c_data = cmd_data;
    end else begin
      push   = wr_done;
      c_row  = row_q;
      c_col  = col_q;
      c_data = wdata_q;
    end
  end
  assign pop = rd_done && !dir_q;

  // FSM state register with command latches and delay counter.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      dir_q   <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      dir_q   <= dir_d;
      wdata_q <= wdata_d;
    end
  end

  // FSM next-state: command acceptance, latency counting and read abort.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    col_d   = col_q;
    dir_d   = dir_q;
    wdata_d = wdata_q;
    case (state_q)
      StIdle: begin
        if (wr_go && (WR_DLY != 0)) begin
          state_d = StWrite;
          cnt_d   = TW'(WR_DLY);
          row_d   = cmd_row;
          col_d   = cmd_col;
          wdata_d = cmd_data;
        end else if (rd_go) begin
          state_d = StRdWait;
          cnt_d   = TW'(RD_DLY);
          row_d   = cmd_row;
          col_d   = cmd_col;
          dir_d   = cmd_dir;
        end
      end
      StWrite: begin
        if (wr_done) state_d = StIdle;
        else         cnt_d   = cnt_q - TW'(1);
      end
      StRdWait: begin
        if (rd_abort) begin
          state_d = StIdle;
        end else if (rd_done) begin
          state_d = StRdHold;
          cnt_d   = TW'(RD_HOLD);
        end else begin
          cnt_d = cnt_q - TW'(1);
        end
      end
      StRdHold: begin
        if (hold_done) state_d = StIdle;
        else           cnt_d   = cnt_q - TW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  // Output next-values: acks, error qualifier and read data.
  always_comb begin
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      StIdle: begin
        if (wr_bad) begin
          ack_d = 1'b1;
          err_d = 1'b1;
        end else if (wr_go && (WR_DLY == 0)) begin
          ack_d = 1'b1;
        end
        if (rd_bad) begin
          ack_d   = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      StWrite:  ack_d = wr_done;
      StRdWait: begin
        if (rd_done) begin
          ack_d   = 1'b1;
          rdata_d = rd_word;
        end
      end
      StRdHold: ack_d = !hold_done;
      default:  ack_d = 1'b0;
    endcase
  end

  // Queue occupancy next-value; push and pop are mutually exclusive.
  always_comb begin
    count_d = count_q;
    if (push)     count_d = count_q + CW'(1);
    else if (pop) count_d = count_q - CW'(1);
  end

  // Registered outputs and queue pointers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      busy_q  <= (state_d != StIdle);
      count_q <= count_d;
      full_q  <= (count_d == CW'(QDEPTH));
      empty_q <= (count_d == '0);
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
    end
  end

  // Array and address-queue storage; contents survive reset.
  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      mem_q[cell_idx(c_row, c_col)] <= c_data;
      addrq_q[wptr_q]               <= {c_row, c_col};
    end
  end

  assign read_data = {{(32 - DW){1'b0}}, rdata_q};
  assign func_ack  = ack_q;
  assign func_err  = err_q;
  assign busy      = busy_q;
  assign q_count   = count_q;
  assign q_full    = full_q;
  assign q_empty   = empty_q;

endmodule
